// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MDU busy, branch squash, overflow entry.
// Latency: stall/flush/exc_pc_sel are same-cycle combinational; kill_W, mdu_done, epc, exc_count are registered.
// Backpressure: stall_F/stall_D hold the front end; a branch or overflow overrides any stall, and an overflow aborts the MDU.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rs_D, rt_D, mdu_use_D      ID-stage source registers and HI/LO / mult-div use
//   RegWr_E, MemtoReg_E,
//   RegWrDst_E, mdu_start_E    EX-stage write info and MDU issue
//   branch_taken_M,
//   if_overflow_M, PC_M        MEM-stage redirect, overflow and PC
//   stall_F, stall_D           hold PC and IF/ID
//   flush_D, flush_E, flush_M  bubble IF/ID, ID/EX, EX/MEM
//   kill_W                     registered writeback kill
//   exc_pc_sel                 select the exception vector
//   mdu_busy, mdu_done         MDU occupancy and free pulse
//   epc, exc_count             exception PC and saturating overflow count
module pipe_hazard_ctrl #(
  parameter int MDU_LAT   = 32,
  parameter int EXC_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs_D,
  input  logic [4:0]           rt_D,
  input  logic                 mdu_use_D,
  input  logic                 RegWr_E,
  input  logic                 MemtoReg_E,
  input  logic [4:0]           RegWrDst_E,
  input  logic                 mdu_start_E,
  input  logic                 branch_taken_M,
  input  logic                 if_overflow_M,
  input  logic [31:0]          PC_M,
  output logic                 stall_F,
  output logic                 stall_D,
  output logic                 flush_D,
  output logic                 flush_E,
  output logic                 flush_M,
  output logic                 kill_W,
  output logic                 exc_pc_sel,
  output logic                 mdu_busy,
  output logic                 mdu_done,
  output logic [31:0]          epc,
  output logic [EXC_CNT_W-1:0] exc_count
);

  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mdu_done_q, mdu_done_d;
  logic                 kill_q, kill_d;
  logic [31:0]          epc_q, epc_d;
  logic [EXC_CNT_W-1:0] exc_cnt_q, exc_cnt_d;

  logic load_use;
  logic mdu_stall;

  // Load in EX feeding ID: one bubble suffices since the load reaches MEM next cycle.
  assign load_use = MemtoReg_E && RegWr_E && (RegWrDst_E != 5'd0) &&
                    ((RegWrDst_E == rs_D) || (RegWrDst_E == rt_D));
  assign mdu_stall = (state_q == MDU_BUSY) && mdu_use_D;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdu_done_d = 1'b0;
    kill_d     = 1'b0;
    epc_d      = epc_q;
    exc_cnt_d  = exc_cnt_q;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    flush_M    = 1'b0;
    exc_pc_sel = 1'b0;

    // Pipeline control: overflow > branch > MDU/load-use stall (one shared stall set).
    if (if_overflow_M) begin
      exc_pc_sel = 1'b1;
      flush_D    = 1'b1;
      flush_E    = 1'b1;
      flush_M    = 1'b1;
    end else if (branch_taken_M) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_M = 1'b1;
    end else if (load_use || mdu_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end

    // MDU sequencing
    if (if_overflow_M) begin
      // Overflow aborts any in-flight MDU op without a done pulse.
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mdu_start_E && !branch_taken_M) begin
            state_d = MDU_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        MDU_BUSY: begin
          // An op issued before a taken branch keeps running; re-issue is ignored.
          if (cnt_q == '0) begin
            state_d    = RUN;
            mdu_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    // Exception capture
    if (if_overflow_M) begin
      kill_d = 1'b1;
      epc_d  = PC_M;
      if (exc_cnt_q != {EXC_CNT_W{1'b1}}) begin
        exc_cnt_d = exc_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mdu_done_q <= 1'b0;
      kill_q     <= 1'b0;
      epc_q      <= '0;
      exc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mdu_done_q <= mdu_done_d;
      kill_q     <= kill_d;
      epc_q      <= epc_d;
      exc_cnt_q  <= exc_cnt_d;
    end
  end

  assign mdu_busy  = (state_q == MDU_BUSY);
  assign mdu_done  = mdu_done_q;
  assign kill_W    = kill_q;
  assign epc       = epc_q;
  assign exc_count = exc_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_D, rt_D, RegWrDst_E;
  logic        mdu_use_D, RegWr_E, MemtoReg_E, mdu_start_E;
  logic        branch_taken_M, if_overflow_M;
  logic [31:0] PC_M;
  logic        stall_F, stall_D, flush_D, flush_E, flush_M, kill_W;
  logic        exc_pc_sel, mdu_busy, mdu_done;
  logic [31:0] epc;
  logic [1:0]  exc_count;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MDU_LAT(4), .EXC_CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .mdu_use_D(mdu_use_D),
    .RegWr_E(RegWr_E), .MemtoReg_E(MemtoReg_E), .RegWrDst_E(RegWrDst_E),
    .mdu_start_E(mdu_start_E),
    .branch_taken_M(branch_taken_M), .if_overflow_M(if_overflow_M), .PC_M(PC_M),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .flush_M(flush_M), .kill_W(kill_W), .exc_pc_sel(exc_pc_sel),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .epc(epc), .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector bit order: {stall_F, stall_D, flush_D, flush_E, flush_M, exc_pc_sel, mdu_busy, mdu_done, kill_W}
  typedef struct {
    logic [4:0]  rs, rt;
    logic        mdu_use, regwr, memtoreg;
    logic [4:0]  dst;
    logic        start, br, ovf;
    logic [31:0] pc;
    logic [8:0]  exp;
  } vec_t;

  function automatic logic [8:0] outs();
    return {stall_F, stall_D, flush_D, flush_E, flush_M, exc_pc_sel, mdu_busy, mdu_done, kill_W};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_D = 0; rt_D = 0; mdu_use_D = 0; RegWr_E = 0; MemtoReg_E = 0; RegWrDst_E = 0;
    mdu_start_E = 0; branch_taken_M = 0; if_overflow_M = 0; PC_M = 0;
  endtask

  task automatic apply(input vec_t v);
    rs_D = v.rs; rt_D = v.rt; mdu_use_D = v.mdu_use; RegWr_E = v.regwr;
    MemtoReg_E = v.memtoreg; RegWrDst_E = v.dst; mdu_start_E = v.start;
    branch_taken_M = v.br; if_overflow_M = v.ovf; PC_M = v.pc;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic mu,
                              input logic rw, input logic m2r, input logic [4:0] dst,
                              input logic st, input logic br, input logic ovf,
                              input logic [31:0] pc, input logic [8:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.mdu_use = mu; v.regwr = rw; v.memtoreg = m2r; v.dst = dst;
    v.start = st; v.br = br; v.ovf = ovf; v.pc = pc; v.exp = exp;
    return v;
  endfunction

  vec_t vecs[13];
  logic [1:0] sat_exp[5];

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     9'b000000000); // idle
    vecs[1]  = mk(8, 0, 0, 1, 1, 8, 0, 0, 0, 0,     9'b110100000); // lw $8, rs=8
    vecs[2]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0,     9'b000000000); // load to $0 never stalls
    vecs[3]  = mk(0, 8, 0, 1, 1, 8, 0, 0, 0, 0,     9'b110100000); // lw $8, rt=8
    vecs[4]  = mk(8, 0, 0, 0, 1, 8, 0, 0, 0, 0,     9'b000000000); // no RegWr
    vecs[5]  = mk(8, 0, 0, 1, 0, 8, 0, 0, 0, 0,     9'b000000000); // ALU op, forwardable
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0,     9'b000000000); // mdu_use while idle
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,     9'b001110000); // branch
    vecs[8]  = mk(8, 0, 0, 1, 1, 8, 0, 1, 0, 0,     9'b001110000); // branch beats load-use
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,     9'b001110000); // branch cancels mdu start
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     9'b000000000); // MDU stayed idle
    vecs[11] = mk(8, 0, 0, 1, 1, 8, 0, 1, 1, 32'h100, 9'b001111000); // overflow beats all
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     9'b000000001); // kill_W one cycle later
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_exc_count", 32'(exc_count), 32'd0);
    tick();

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      tick();
    end
    chk("vec_epc", epc, 32'h100);
    chk("vec_exc_count", 32'(exc_count), 32'd1);

    // MDU stall: 4 busy cycles with stall, then done pulse with stall released
    do_reset();
    mdu_start_E = 1'b1;
    #2;
    chk("mdu_issue_busy", 32'(mdu_busy), 32'd0);
    tick();
    mdu_start_E = 1'b0;
    mdu_use_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("mdu_busy_c%0d", i + 1), 32'(outs()), 32'(9'b110100100));
      tick();
    end
    #2;
    chk("mdu_done_c5", 32'(outs()), 32'(9'b000000010));
    tick();
    chk("mdu_done_gone", 32'(mdu_done), 32'd0);
    idle();

    // Branch during busy keeps the MDU running; overflow at counter=2 aborts it
    do_reset();
    mdu_start_E = 1'b1;
    tick();                              // counter = 3
    mdu_start_E = 1'b0;
    branch_taken_M = 1'b1;
    #2;
    chk("busy_branch_flush", 32'(outs()), 32'(9'b001110100));
    tick();                              // counter = 2
    branch_taken_M = 1'b0;
    chk("busy_after_branch", 32'(mdu_busy), 32'd1);
    if_overflow_M = 1'b1;
    PC_M = 32'h0040_0018;
    #2;
    chk("ovf_exc_pc_sel", 32'(outs()), 32'(9'b001111100));
    tick();
    idle();
    chk("ovf_epc", epc, 32'h0040_0018);
    chk("ovf_regs", 32'({kill_W, mdu_busy, mdu_done}), 32'(3'b100));
    chk("ovf_exc_count", 32'(exc_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ovf_no_done%0d", i), 32'({kill_W, mdu_busy, mdu_done}), 32'd0);
    end

    // Saturation of a 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if_overflow_M = 1'b1;
      PC_M = 32'h0040_0100 + 32'(i * 4);
      tick();
      if_overflow_M = 1'b0;
      chk($sformatf("sat%0d", i), 32'(exc_count), 32'(sat_exp[i]));
    end
    chk("sat_epc", epc, 32'h0040_0110);

    // Reset mid-MDU with a load-use pending
    idle();
    mdu_start_E = 1'b1;
    tick();
    mdu_start_E = 1'b0;
    chk("pre_reset_busy", 32'(mdu_busy), 32'd1);
    rs_D = 5'd9; RegWr_E = 1'b1; MemtoReg_E = 1'b1; RegWrDst_E = 5'd9; mdu_use_D = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #2;
    chk("rst_mid_outs", 32'(outs()), 32'd0);
    chk("rst_mid_epc", epc, 32'd0);
    chk("rst_mid_exc_count", 32'(exc_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rst_no_done%0d", i), 32'({mdu_busy, mdu_done}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. It drives the hold and bubble controls of the IF/ID, ID/EX and EX/MEM registers, and the writeback kill for MEM/WB.
- It covers load-use stalls, multi-cycle multiply/divide busy tracking, taken-branch squash resolved in MEM, and arithmetic-overflow exception entry with EPC capture.
- It sits beside the datapath and is the only source of pipeline-register stall and flush signals.

Parameters:
- MDU_LAT, 32: multiply/divide occupancy in cycles, counted from issue. Legal range is 2 to 255.
- EXC_CNT_W, 8: width of the saturating overflow-event counter.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs_D  in  5  source register 1 of the instruction in ID.
- rt_D  in  5  source register 2 of the instruction in ID.
- mdu_use_D  in  1  instruction in ID reads HI/LO or is itself mult/div.
- RegWr_E  in  1  instruction in EX writes the register file.
- MemtoReg_E  in  1  instruction in EX is a load.
- RegWrDst_E  in  5  destination register of the instruction in EX.
- mdu_start_E  in  1  mult/div instruction is in EX this cycle.
- branch_taken_M  in  1  branch/jump in MEM redirects the PC.
- if_overflow_M  in  1  instruction in MEM overflowed.
- PC_M  in  32  PC of the instruction in MEM.
- stall_F  out  1  hold the PC.
- stall_D  out  1  hold IF/ID.
- flush_D  out  1  bubble IF/ID.
- flush_E  out  1  bubble ID/EX.
- flush_M  out  1  bubble EX/MEM.
- kill_W  out  1  registered; gates RegWr in the WB stage.
- exc_pc_sel  out  1  select the exception vector as next PC.
- mdu_busy  out  1  MDU occupied.
- mdu_done  out  1  one-cycle pulse when the MDU frees.
- epc  out  32  PC of the last overflowing instruction.
- exc_count  out  EXC_CNT_W  saturating count of overflow events.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - State goes to RUN, the MDU counter to 0, and epc, exc_count, kill_W and mdu_done to 0.
  - All combinational outputs are 0 while state is RUN and inputs are idle.
  - Reset mid-MDU abandons the operation with no mdu_done pulse.
- States:
  - RUN: MDU idle.
  - MDU_BUSY: counter running, mdu_busy=1.
- Load-use hazard, in either state:
  - Condition: MemtoReg_E & RegWr_E & RegWrDst_E!=0 & (RegWrDst_E==rs_D | RegWrDst_E==rt_D).
  - Response, same cycle (combinational): stall_F=1, stall_D=1, flush_E=1. This gives exactly one bubble, because the next cycle the load is in MEM.
- MDU issue:
  - In RUN, mdu_start_E=1 with no branch_taken_M and no if_overflow_M gives next state MDU_BUSY with counter=MDU_LAT-1.
  - mdu_start_E while already in MDU_BUSY is ignored. Decode guarantees this cannot happen because mdu_use_D stalls first.
- MDU_BUSY:
  - mdu_busy=1 and the counter decrements each cycle.
  - If mdu_use_D=1: stall_F=1, stall_D=1, flush_E=1.
  - When counter==0: next state RUN and mdu_done=1 for one cycle (registered, in the first RUN cycle). The stall releases in that same first RUN cycle.
- Taken branch (branch_taken_M=1):
  - flush_D=1, flush_E=1, flush_M=1; stall_F and stall_D are forced to 0 so the PC loads the target.
  - mdu_start_E in the same cycle is cancelled.
  - An MDU already in MDU_BUSY continues, because it was issued before the branch.
- Overflow (if_overflow_M=1):
  - Same cycle: exc_pc_sel=1, flush_D=1, flush_E=1, flush_M=1, stall_F=0, stall_D=0.
  - Next edge: epc<=PC_M, kill_W<=1 for one cycle, and exc_count increments, saturating at all-ones.
  - Any MDU_BUSY operation is aborted: next state RUN, counter 0, no mdu_done.
- Priority: overflow > branch > MDU stall/issue > load-use. A lower-priority stall never masks a higher-priority flush.
- Simultaneous load-use and mdu_use_D give the same single stall/flush set; the effects are not additive.
- Counter width is ceil(log2(MDU_LAT)); the counter never wraps because it only loads in RUN.

Test Plan:
- Load-use: EX=lw $8 (MemtoReg_E=1, RegWr_E=1, RegWrDst_E=8), rs_D=8 -> stall_F, stall_D and flush_E high exactly 1 cycle. The same stimulus with RegWrDst_E=0 -> no stall.
- MDU stall: MDU_LAT=4, mdu_start_E pulse, then mdu_use_D held -> mdu_busy high 4 cycles, stall high those 4 cycles, mdu_done pulses in cycle 5 with stall low.
- Branch squash: branch_taken_M=1 with mdu_start_E=1 in RUN -> flush_D, flush_E and flush_M high, state stays RUN, mdu_busy stays 0.
- Overflow during MDU: in MDU_BUSY (counter=2), if_overflow_M=1, PC_M=0x0040_0018 -> exc_pc_sel=1 that cycle; next cycle epc=0x0040_0018, kill_W=1, exc_count=1, mdu_busy=0, no mdu_done.
- Saturation: EXC_CNT_W=2, 5 overflow pulses -> exc_count sequence 1, 2, 3, 3, 3.
- Reset mid-operation: rst=1 during MDU_BUSY with a load-use pending -> next cycle all outputs 0, epc=0, state RUN.
